// File: rtl/multicycle_controller.sv
// Multicycle ARM-subset controller: main FSM, ALU/flag decode, flag register
// and condition check. Optional feature macro: COND_EXEC_EN -- when defined,
// CondEx is evaluated from Cond and the flag register at the end of DECODE;
// when undefined, CondEx is constant 1 and Cond is ignored.
`timescale 1ns/1ps

module multicycle_controller (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] Cond,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] ALUFlags,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [1:0] ALUControl
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECUTER = 4'd6;
  localparam logic [3:0] S_EXECUTEI = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  // ALU operation for a data-processing command; unknown commands add.
  function automatic logic [1:0] alu_decode(input logic [3:0] cmd);
    case (cmd)
      CMD_ADD: alu_decode = 2'b00;
      CMD_SUB: alu_decode = 2'b01;
      CMD_CMP: alu_decode = 2'b01;
      CMD_AND: alu_decode = 2'b10;
      CMD_ORR: alu_decode = 2'b11;
      default: alu_decode = 2'b00;
    endcase
  endfunction

  // Flag write mask {NZ, CV}: arithmetic updates all four, logic only N/Z.
  function automatic logic [1:0] flag_write(input logic [5:0] funct);
    if (funct[0] == 1'b0) begin
      flag_write = 2'b00;
    end else begin
      case (funct[4:1])
        CMD_ADD, CMD_SUB, CMD_CMP: flag_write = 2'b11;
        CMD_AND, CMD_ORR:          flag_write = 2'b10;
        default:                   flag_write = 2'b00;
      endcase
    end
  endfunction

  logic [3:0] state_r;
  logic [3:0] state_next_s;
  logic [3:0] flags_r;          // {N, Z, C, V}
  logic [3:0] flags_next_s;
  logic       cond_ex_s;
  logic [3:0] cmd_s;
  logic       exec_state_s;
  logic       wb_state_s;
  logic       pc_base_s;
  logic       ir_write_s;
  logic       reg_write_s;
  logic       mem_write_s;
  logic       branch_s;
  logic [1:0] flag_w_s;

  assign cmd_s        = Funct[4:1];
  assign exec_state_s = (state_r == S_EXECUTER) || (state_r == S_EXECUTEI);
  assign wb_state_s   = (state_r == S_MEMWB) || (state_r == S_ALUWB) || (state_r == S_BRANCH);
  assign flag_w_s     = flag_write(Funct);

`ifdef COND_EXEC_EN
  // ARM condition check: pairs of codes share a base test, the low bit inverts it.
  // 1110 is "always"; its inverse 1111 therefore never executes.
  function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v, base;
    n = nzcv[3];
    z = nzcv[2];
    c = nzcv[1];
    v = nzcv[0];
    case (cond[3:1])
      3'b000:  base = z;
      3'b001:  base = c;
      3'b010:  base = n;
      3'b011:  base = v;
      3'b100:  base = c & ~z;
      3'b101:  base = (n == v);
      3'b110:  base = ~z & (n == v);
      3'b111:  base = 1'b1;
      default: base = 1'b0;
    endcase
    cond_eval = base ^ cond[0];
  endfunction

  logic cond_ex_r;

  // Capture the condition once per instruction so its own flag update cannot gate its writeback.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cond_ex_r <= 1'b0;
    end else if (state_r == S_DECODE) begin
      cond_ex_r <= cond_eval(Cond, flags_r);
    end else begin
      cond_ex_r <= cond_ex_r;
    end
  end

  assign cond_ex_s = cond_ex_r;
`else
  logic unused_cond_s;

  assign cond_ex_s     = 1'b1;
  assign unused_cond_s = ^{Cond, flags_r};
`endif

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_next_s = S_FETCH;
    case (state_r)
      S_FETCH:  state_next_s = S_DECODE;
      S_DECODE: begin
        case (Op)
          2'b01:   state_next_s = S_MEMADR;
          2'b00:   state_next_s = Funct[5] ? S_EXECUTEI : S_EXECUTER;
          2'b10:   state_next_s = S_BRANCH;
          default: state_next_s = S_FETCH;
        endcase
      end
      S_MEMADR:   state_next_s = Funct[0] ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_next_s = S_MEMWB;
      S_MEMWB:    state_next_s = S_FETCH;
      S_MEMWRITE: state_next_s = S_FETCH;
      S_EXECUTER,
      S_EXECUTEI: state_next_s = (cmd_s == CMD_CMP) ? S_FETCH : S_ALUWB;
      S_ALUWB:    state_next_s = S_FETCH;
      S_BRANCH:   state_next_s = S_FETCH;
      default:    state_next_s = S_FETCH;
    endcase
  end

  // Flag update: masked load at the end of an executed data-processing step.
  always_comb begin
    flags_next_s = flags_r;
    if (exec_state_s && cond_ex_s) begin
      if (flag_w_s[1]) begin
        flags_next_s[3:2] = ALUFlags[3:2];
      end else begin
        flags_next_s[3:2] = flags_r[3:2];
      end
      if (flag_w_s[0]) begin
        flags_next_s[1:0] = ALUFlags[1:0];
      end else begin
        flags_next_s[1:0] = flags_r[1:0];
      end
    end else begin
      flags_next_s = flags_r;
    end
  end

  // Flag register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flags_r <= 4'b0000;
    end else begin
      flags_r <= flags_next_s;
    end
  end

  // Per-state datapath controls.
  always_comb begin
    pc_base_s   = 1'b0;
    ir_write_s  = 1'b0;
    reg_write_s = 1'b0;
    mem_write_s = 1'b0;
    branch_s    = 1'b0;
    AdrSrc      = 1'b0;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    ResultSrc   = 2'b00;
    case (state_r)
      S_FETCH: begin
        ir_write_s = 1'b1;
        pc_base_s  = 1'b1;
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
      end
      S_DECODE: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      S_MEMADR:  ALUSrcB = 2'b01;
      S_MEMREAD: AdrSrc  = 1'b1;
      S_MEMWB: begin
        ResultSrc   = 2'b01;
        reg_write_s = cond_ex_s;
      end
      S_MEMWRITE: begin
        AdrSrc      = 1'b1;
        mem_write_s = cond_ex_s;
      end
      S_EXECUTER: ALUSrcB = 2'b00;
      S_EXECUTEI: ALUSrcB = 2'b01;
      S_ALUWB:    reg_write_s = cond_ex_s;
      S_BRANCH: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        branch_s  = 1'b1;
      end
      default: begin
        pc_base_s = 1'b0;
      end
    endcase
  end

  // Write enables, forced low while reset is held; PC follows the result bus in writeback states.
  always_comb begin
    if (wb_state_s) begin
      PCWrite = reset_n & cond_ex_s & (branch_s | (reg_write_s & (Rd == 4'd15)));
    end else begin
      PCWrite = reset_n & pc_base_s;
    end
    IRWrite    = reset_n & ir_write_s;
    RegWrite   = reset_n & reg_write_s;
    MemWrite   = reset_n & mem_write_s;
    ImmSrc     = Op;
    RegSrc     = {(Op == 2'b01), (Op == 2'b10)};
    if (exec_state_s) begin
      ALUControl = alu_decode(cmd_s);
    end else begin
      ALUControl = 2'b00;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: an instruction-level model
// (per-instruction step lists, flag/condition rules) checked every cycle,
// plus directed instruction sequences with literal expectations.
`timescale 1ns/1ps

module tb_multicycle_controller;

  localparam int PH_END = -1;
  localparam int PH_F   = 1;   // fetch
  localparam int PH_D   = 2;   // decode
  localparam int PH_MA  = 3;   // memory address
  localparam int PH_MR  = 4;   // memory read
  localparam int PH_MWB = 5;   // load writeback
  localparam int PH_MW  = 6;   // store
  localparam int PH_ER  = 7;   // execute register
  localparam int PH_EI  = 8;   // execute immediate
  localparam int PH_AW  = 9;   // ALU writeback
  localparam int PH_B   = 10;  // branch

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] Cond, Rd, ALUFlags;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         m_pos    = 0;
  logic [3:0] m_flags  = 4'd0;
  logic       m_condex = 1'b0;
  int         ph_s;
  logic [16:0] exp_s, act_s;

  logic [9:0] lg_rw, lg_pc;
  logic [1:0] lg_alu [0:9];
  int         ncyc;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk(clk), .reset_n(reset_n), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
    .ALUFlags(ALUFlags), .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Step list of an instruction, derived from its class and fields.
  function automatic int phase_at(input logic [1:0] op, input logic [5:0] f, input int pos);
    int seq[$];
    seq = {PH_F, PH_D};
    case (op)
      2'b01: begin
        seq.push_back(PH_MA);
        if (f[0]) begin
          seq.push_back(PH_MR);
          seq.push_back(PH_MWB);
        end else begin
          seq.push_back(PH_MW);
        end
      end
      2'b00: begin
        seq.push_back(f[5] ? PH_EI : PH_ER);
        if (f[4:1] != 4'b1010) seq.push_back(PH_AW);
      end
      2'b10: seq.push_back(PH_B);
      default: ;
    endcase
    if (pos < seq.size()) return seq[pos];
    return PH_END;
  endfunction

  function automatic logic [1:0] alu_of(input logic [3:0] cmd);
    if (cmd == 4'b0100) return 2'b00;
    if (cmd == 4'b0010 || cmd == 4'b1010) return 2'b01;
    if (cmd == 4'b0000) return 2'b10;
    if (cmd == 4'b1100) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic cond_model(input logic [3:0] c, input logic [3:0] fl);
`ifdef COND_EXEC_EN
    logic n, z, cy, v;
    n = fl[3]; z = fl[2]; cy = fl[1]; v = fl[0];
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !cy || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
`else
    return 1'b1 | (^{c, fl} & 1'b0);
`endif
  endfunction

  function automatic logic [3:0] flag_model(input logic [3:0] old, input logic [3:0] alu, input logic [5:0] f);
    if (!f[0]) return old;
    if (f[4:1] == 4'b0100 || f[4:1] == 4'b0010 || f[4:1] == 4'b1010) return alu;
    if (f[4:1] == 4'b0000 || f[4:1] == 4'b1100) return {alu[3:2], old[1:0]};
    return old;
  endfunction

  // Expected outputs packed as {PCW,IRW,RW,MW,AdrSrc,SrcA,SrcB,Res,Imm,RegSrc,ALUCtl}.
  function automatic logic [16:0] expect_out(input int ph, input logic cx, input logic [1:0] op,
                                             input logic [5:0] f, input logic [3:0] rd, input logic in_rst);
    logic pcw, irw, rw, mw, adr;
    logic [1:0] a, b, res, alu;
    pcw = 1'b0; irw = 1'b0; rw = 1'b0; mw = 1'b0; adr = 1'b0;
    a = 2'b00; b = 2'b00; res = 2'b00; alu = 2'b00;
    case (ph)
      PH_F:   begin irw = 1'b1; pcw = 1'b1; a = 2'b01; b = 2'b10; res = 2'b10; end
      PH_D:   begin a = 2'b01; b = 2'b10; res = 2'b10; end
      PH_MA:  b = 2'b01;
      PH_MR:  adr = 1'b1;
      PH_MWB: begin res = 2'b01; rw = cx; pcw = cx && (rd == 4'd15); end
      PH_MW:  begin adr = 1'b1; mw = cx; end
      PH_ER:  alu = alu_of(f[4:1]);
      PH_EI:  begin b = 2'b01; alu = alu_of(f[4:1]); end
      PH_AW:  begin rw = cx; pcw = cx && (rd == 4'd15); end
      PH_B:   begin a = 2'b10; b = 2'b01; res = 2'b10; pcw = cx; end
      default: ;
    endcase
    if (in_rst) begin
      pcw = 1'b0; irw = 1'b0; rw = 1'b0; mw = 1'b0;
    end
    return {pcw, irw, rw, mw, adr, a, b, res, op, (op == 2'b01), (op == 2'b10), alu};
  endfunction

  // Model's expected view of the current cycle.
  always_comb begin
    ph_s  = phase_at(Op, Funct, m_pos);
    act_s = {PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
             ImmSrc, RegSrc, ALUControl};
    if (!reset_n) exp_s = expect_out(PH_F, 1'b0, Op, Funct, Rd, 1'b1);
    else          exp_s = expect_out(ph_s, m_condex, Op, Funct, Rd, 1'b0);
  end

  // Per-cycle compare on the falling edge, then advance the model.
  always @(negedge clk) begin
    check($sformatf("cycle step=%0d", ph_s), {15'd0, act_s}, {15'd0, exp_s});
    if (!reset_n) begin
      m_pos   <= 0;
      m_flags <= 4'd0;
`ifdef COND_EXEC_EN
      m_condex <= 1'b0;
`else
      m_condex <= 1'b1;
`endif
    end else begin
      m_pos <= (phase_at(Op, Funct, m_pos + 1) == PH_END) ? 0 : m_pos + 1;
      if (ph_s == PH_D) m_condex <= cond_model(Cond, m_flags);
      if ((ph_s == PH_ER || ph_s == PH_EI) && m_condex)
        m_flags <= flag_model(m_flags, ALUFlags, Funct);
    end
  end

  // Run one instruction from its FETCH cycle, logging outputs per cycle.
  task automatic issue(input logic [3:0] c, input logic [1:0] op, input logic [5:0] f,
                       input logic [3:0] rd, input logic [3:0] fl, input bit rnd);
    Cond = c; Op = op; Funct = f; Rd = rd;
    ALUFlags = rnd ? 4'($urandom) : fl;
    ncyc = 0; lg_rw = '0; lg_pc = '0;
    do begin
      #2;
      lg_rw[ncyc] = RegWrite;
      lg_pc[ncyc] = PCWrite;
      lg_alu[ncyc] = ALUControl;
      ncyc++;
      @(posedge clk); #1;
      ALUFlags = rnd ? 4'($urandom) : fl;
    end while (m_pos != 0 && ncyc < 10);
    if (m_pos != 0) check("instruction timeout", 32'(m_pos), 32'd0);
  endtask

  logic [3:0] exp_rw4, exp_pc4;
  logic [2:0] exp_bne;

  initial begin
    reset_n = 1'b0; Cond = 4'd0; Op = 2'd0; Funct = 6'd0; Rd = 4'd0; ALUFlags = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset enables", {28'd0, PCWrite, IRWrite, RegWrite, MemWrite}, 32'd0);
    check("reset srcB", {30'd0, ALUSrcB}, 32'd2);
    check("reset result", {30'd0, ResultSrc}, 32'd2);
    reset_n = 1'b1;
    #1;
    check("first fetch irw", {31'd0, IRWrite}, 32'd1);
    check("first fetch pcw", {31'd0, PCWrite}, 32'd1);

    // LDR r3
    issue(4'b1110, 2'b01, 6'b011001, 4'd3, 4'd0, 1'b1);
    check("ldr cycles", 32'(ncyc), 32'd5);
    check("ldr regwrite", {27'd0, lg_rw[4:0]}, 32'h10);
    check("ldr pcwrite", {27'd0, lg_pc[4:0]}, 32'h01);

    // SUBS r2 with Z result, then BEQ / BNE
    issue(4'b1110, 2'b00, 6'b000101, 4'd2, 4'b0100, 1'b0);
    check("subs cycles", 32'(ncyc), 32'd4);
    check("subs alu", {30'd0, lg_alu[2]}, 32'd1);
    check("subs regwrite", {28'd0, lg_rw[3:0]}, 32'h8);
    issue(4'b0000, 2'b10, 6'b000000, 4'd0, 4'b0000, 1'b0);
    check("beq cycles", 32'(ncyc), 32'd3);
    check("beq pcwrite", {29'd0, lg_pc[2:0]}, 32'h5);
`ifdef COND_EXEC_EN
    exp_bne = 3'b001;
`else
    exp_bne = 3'b101;
`endif
    issue(4'b0001, 2'b10, 6'b000000, 4'd0, 4'b0000, 1'b0);
    check("bne pcwrite", {29'd0, lg_pc[2:0]}, {29'd0, exp_bne});

    // CMP: no writeback step
    issue(4'b1110, 2'b00, 6'b010101, 4'd5, 4'b0100, 1'b0);
    check("cmp cycles", 32'(ncyc), 32'd3);
    check("cmp alu", {30'd0, lg_alu[2]}, 32'd1);
    check("cmp regwrite", {29'd0, lg_rw[2:0]}, 32'd0);

    // ADD pc, always then NE with Z set
    issue(4'b1110, 2'b00, 6'b001000, 4'd15, 4'b0000, 1'b0);
    check("add pc cycles", 32'(ncyc), 32'd4);
    check("add pc regwrite", {28'd0, lg_rw[3:0]}, 32'h8);
    check("add pc pcwrite", {28'd0, lg_pc[3:0]}, 32'h9);
`ifdef COND_EXEC_EN
    exp_rw4 = 4'b0000; exp_pc4 = 4'b0001;
`else
    exp_rw4 = 4'b1000; exp_pc4 = 4'b1001;
`endif
    issue(4'b0001, 2'b00, 6'b001000, 4'd15, 4'b0000, 1'b0);
    check("addne pc regwrite", {28'd0, lg_rw[3:0]}, {28'd0, exp_rw4});
    check("addne pc pcwrite", {28'd0, lg_pc[3:0]}, {28'd0, exp_pc4});

    // Reset in the middle of a store's address step
    Cond = 4'b1110; Op = 2'b01; Funct = 6'b011000; Rd = 4'd4;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #1 check("memadr srcB", {30'd0, ALUSrcB}, 32'd1);
    reset_n = 1'b0;
    #1 check("abort enables", {28'd0, PCWrite, IRWrite, RegWrite, MemWrite}, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    #1;
    check("post-abort irw/pcw", {30'd0, IRWrite, PCWrite}, 32'd3);
    check("post-abort memwrite", {31'd0, MemWrite}, 32'd0);

    // Randomized instruction stream with occasional mid-instruction resets
    for (int i = 0; i < 400; i++) begin
      logic [3:0] cmd, c, rd;
      logic [5:0] f;
      int sel;
      sel = int'($urandom_range(0, 5));
      case (sel)
        0: cmd = 4'b0100;
        1: cmd = 4'b0010;
        2: cmd = 4'b1010;
        3: cmd = 4'b0000;
        4: cmd = 4'b1100;
        default: cmd = 4'($urandom);
      endcase
      f  = {1'($urandom), cmd, 1'($urandom)};
      rd = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom);
      c  = ($urandom_range(0, 3) == 0) ? 4'b1110 : 4'($urandom);
      if ($urandom_range(0, 24) == 0) begin
        Cond = c; Op = 2'($urandom); Funct = f; Rd = rd;
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk); #1;
          ALUFlags = 4'($urandom);
        end
        reset_n = 1'b0;
        repeat ($urandom_range(1, 2)) begin
          @(posedge clk); #1;
        end
        reset_n = 1'b1;
        #1 check("rand reset fetch", {31'd0, IRWrite}, 32'd1);
      end else begin
        issue(c, 2'($urandom), f, rd, 4'd0, 1'b1);
      end
    end

    @(posedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 reset_n  in  1  asynchronous, active-low reset.
REQ-003 Cond  in  4  instruction condition field, Instr[31:28].
REQ-004 Op  in  2  instruction class, Instr[27:26].
REQ-005 Funct  in  6  Instr[25:20]: I, cmd[3:0], S/L.
REQ-006 Rd  in  4  destination register, Instr[15:12].
REQ-007 ALUFlags  in  4  {N,Z,C,V} from the ALU in the current cycle.
REQ-008 PCWrite, IRWrite, RegWrite, MemWrite  out  1 each  datapath write enables.
REQ-009 AdrSrc  out  1  memory address: 0 = PC, 1 = ALU result register.
REQ-010 ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl  out  2 each  datapath mux selects and ALU operation.

Function
REQ-011 State encodings SHALL be: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, EXECUTEI 7, ALUWB 8, BRANCH 9; codes 10-15 SHALL go to FETCH on the next edge.
REQ-012 Transitions SHALL be:
- FETCH->DECODE.
- DECODE: Op=01->MEMADR; Op=00 & Funct[5]=0->EXECUTER; Op=00 & Funct[5]=1->EXECUTEI; Op=10->BRANCH; Op=11->FETCH with no writes.
- MEMADR: Funct[0]=1->MEMREAD, else MEMWRITE.
- MEMREAD->MEMWB->FETCH; MEMWRITE->FETCH.
- EXECUTER/EXECUTEI: CMP->FETCH, else ALUWB; ALUWB->FETCH; BRANCH->FETCH.
REQ-013 Per-state outputs SHALL be as follows; unlisted selects are 00, unlisted enables are 0:
- FETCH: IRWrite=1, PCWrite=1, AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ResultSrc=10, ALUControl=00.
- DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10.
- MEMADR: ALUSrcB=01.
- MEMREAD: AdrSrc=1.
- MEMWB: ResultSrc=01, RegWrite=CondEx.
- MEMWRITE: AdrSrc=1, MemWrite=CondEx.
- EXECUTER: ALUSrcB=00. EXECUTEI: ALUSrcB=01.
- ALUWB: RegWrite=CondEx.
- BRANCH: ALUSrcA=10, ALUSrcB=01, ResultSrc=10.
REQ-014 In the MEMWB, ALUWB and BRANCH states, PCWrite SHALL equal CondEx & (Branch | (RegWrite & Rd==15)); in those states PC gets the result bus.
REQ-015 ImmSrc SHALL equal Op and RegSrc SHALL equal {Op==01, Op==10} in every state.
REQ-016 ALUControl SHALL be 00 (ADD) outside EXECUTER/EXECUTEI. In those states, Funct[4:1] SHALL map 0100->00 ADD, 0010->01 SUB, 1010->01 CMP, 0000->10 AND, 1100->11 ORR; any other value SHALL give 00.
REQ-017 FlagW[1:0] ({NZ,CV}) SHALL be 00 unless Funct[0]=1. When Funct[0]=1, FlagW SHALL be 11 for ADD/SUB/CMP and 10 for AND/ORR.
REQ-018 The flag register {N,Z,C,V} SHALL load ALUFlags at the end of EXECUTER/EXECUTEI, per FlagW bit, only when CondEx=1.
REQ-019 CondEx SHALL be registered at the end of DECODE from Cond and the flag register, and held until the next DECODE. This keeps a same-instruction flag update out of that instruction's writeback.
REQ-020 Condition evaluation SHALL follow ARM: EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V, HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V), AL 1; 1111 SHALL evaluate to 0.
REQ-021 When CondEx=0, the state sequence SHALL be unchanged and only RegWrite, MemWrite, flag load and the REQ-014 PCWrite SHALL be suppressed.

Reset
REQ-022 While reset_n=0: state=FETCH, flag register=0000, CondEx=0, and PCWrite, IRWrite, RegWrite and MemWrite SHALL be forced 0; mux selects take their FETCH values.
REQ-023 An assertion mid-instruction SHALL abort it immediately with no further writes. The first FETCH write enables SHALL assert in the first cycle after reset_n rises.

Configuration
REQ-024 With COND_EXEC_EN defined, CondEx SHALL follow REQ-019/020. Without it, CondEx SHALL be constant 1, the flag register SHALL still load per REQ-018, and Cond SHALL be ignored.

Verification
REQ-025 Reset mid-MEMADR, then release -> next cycle state FETCH, IRWrite=1, PCWrite=1, MemWrite=0.
REQ-026 LDR (Op=01, Funct=011001, Rd=3, Cond=1110) -> 5 cycles FETCH,DECODE,MEMADR,MEMREAD,MEMWB; RegWrite=1 only in MEMWB; PCWrite=0 there.
REQ-027 SUBS (Funct=000101, ALUFlags=0100) then BEQ (Op=10, Cond=0000) -> Z=1 latched; BRANCH asserts PCWrite=1.
REQ-028 CMP (Funct=010101) -> EXECUTER then FETCH, ALUControl=01, no ALUWB, no RegWrite.
REQ-029 ADD with Rd=15, AL -> ALUWB asserts RegWrite=1 and PCWrite=1. With Cond=0001 and Z=1 (COND_EXEC_EN defined), both SHALL be 0.
